// File: rtl/pll_freq_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_freq_mon_pkg
//  Description : Shared types and width helpers for the PLL frequency monitor.
//                Holds the window FSM state encoding and the functions that
//                size the window counter and the good-run counter.
//  Revision    : 1.0  initial release
// ============================================================================
package pll_freq_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    UPDATE = 2'd2
  } mon_state_t;

  // Window counter only has to reach WINDOW_CYCLES-1.
  function automatic int win_cnt_width(input int window_cycles);
    return (window_cycles > 2) ? $clog2(window_cycles) : 1;
  endfunction

  // Good-run counter saturates at LOCK_COUNT.
  function automatic int run_cnt_width(input int lock_count);
    return (lock_count > 0) ? $clog2(lock_count + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_freq_monitor_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pll_clk_edge_sync
//  Description : Brings the asynchronous measured clock into the reference
//                domain through SYNC_STAGES flops, keeps one history flop and
//                produces a single-cycle rising-edge strobe.
//  Ports       : i_clk      reference clock
//                i_rst_n    asynchronous active-low reset
//                i_meas_clk clock under measurement (treated as data)
//                o_edge     one reference cycle per measured rising edge
//  Revision    : 1.0  initial release
// ============================================================================
module pll_clk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_meas_clk,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_meas_clk};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/pll_freq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : pll_freq_monitor
//  Description : Counts rising edges of MEAS_CLK over fixed windows of
//                WINDOW_CYCLES reference cycles, flags whether each count is
//                inside [MIN_COUNT, MAX_COUNT], and qualifies LOCK after
//                LOCK_COUNT consecutive good windows.
//  Ports       : CLK, RESET_N          reference clock, async active-low reset
//                EN                    measurement enable
//                MEAS_CLK              clock under measurement
//                MIN_COUNT/MAX_COUNT   inclusive good range (quasi-static)
//                COUNT                 edge count of last completed window
//                COUNT_VALID           one-cycle pulse on result update
//                IN_RANGE, OVERFLOW    status of last completed window
//                LOCK                  frequency qualified
//                LOST                  one-cycle pulse when a bad window drops LOCK
//  Revision    : 1.0  initial release
// ============================================================================
module pll_freq_monitor
  import pll_freq_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_WIDTH     = 16,
  parameter int LOCK_COUNT    = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 EN,
  input  logic                 MEAS_CLK,
  input  logic [CNT_WIDTH-1:0] MIN_COUNT,
  input  logic [CNT_WIDTH-1:0] MAX_COUNT,
  output logic [CNT_WIDTH-1:0] COUNT,
  output logic                 COUNT_VALID,
  output logic                 IN_RANGE,
  output logic                 OVERFLOW,
  output logic                 LOCK,
  output logic                 LOST
);

  localparam int c_win_w = win_cnt_width(WINDOW_CYCLES);
  localparam int c_run_w = run_cnt_width(LOCK_COUNT);

  localparam logic [c_win_w-1:0]   c_win_last = c_win_w'(WINDOW_CYCLES - 2);
  localparam logic [c_run_w-1:0]   c_lock_n   = c_run_w'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

  logic w_edge;

  mon_state_t           r_state, w_state_nxt;
  logic [c_win_w-1:0]   r_win,   w_win_nxt;
  logic [CNT_WIDTH-1:0] r_ecnt,  w_ecnt_nxt;
  logic                 r_ovf,   w_ovf_nxt;
  logic [c_run_w-1:0]   r_run,   w_run_nxt;
  logic [CNT_WIDTH-1:0] r_count, w_count_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_in,    w_in_nxt;
  logic                 r_ovfo,  w_ovfo_nxt;
  logic                 r_lock,  w_lock_nxt;
  logic                 r_lost,  w_lost_nxt;

  logic                 w_win_good;
  logic [c_run_w-1:0]   w_run_inc;

  pll_clk_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_meas_clk (MEAS_CLK),
    .o_edge     (w_edge)
  );

  // A window whose counter saturated is never good, whatever MAX_COUNT is.
  assign w_win_good = !r_ovf && (MIN_COUNT <= r_ecnt) && (r_ecnt <= MAX_COUNT);
  assign w_run_inc  = (r_run == c_lock_n) ? r_run : r_run + 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_ecnt  <= '0;
      r_ovf   <= 1'b0;
      r_run   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_in    <= 1'b0;
      r_ovfo  <= 1'b0;
      r_lock  <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_ecnt  <= w_ecnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_run   <= w_run_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_in    <= w_in_nxt;
      r_ovfo  <= w_ovfo_nxt;
      r_lock  <= w_lock_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_ecnt_nxt  = r_ecnt;
    w_ovf_nxt   = r_ovf;
    w_run_nxt   = r_run;
    w_count_nxt = r_count;
    w_valid_nxt = 1'b0;
    w_in_nxt    = r_in;
    w_ovfo_nxt  = r_ovfo;
    w_lock_nxt  = r_lock;
    w_lost_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        // The enabling cycle's edge is the first sample of the window.
        if (EN) begin
          w_state_nxt = GATE;
          w_win_nxt   = '0;
          w_ecnt_nxt  = {{(CNT_WIDTH-1){1'b0}}, w_edge};
          w_ovf_nxt   = 1'b0;
        end
      end

      GATE: begin
        if (!EN) begin
          // Abandoned window: results hold, qualification restarts.
          w_state_nxt = IDLE;
          w_lock_nxt  = 1'b0;
          w_run_nxt   = '0;
        end else begin
          w_win_nxt = r_win + 1'b1;
          if (w_edge) begin
            if (r_ecnt == c_cnt_max) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_ecnt_nxt = r_ecnt + 1'b1;
            end
          end
          if (r_win == c_win_last) begin
            w_state_nxt = UPDATE;
          end
        end
      end

      UPDATE: begin
        w_count_nxt = r_ecnt;
        w_ovfo_nxt  = r_ovf;
        w_in_nxt    = w_win_good;
        w_valid_nxt = 1'b1;
        if (w_win_good) begin
          w_run_nxt = w_run_inc;
          if (w_run_inc == c_lock_n) begin
            w_lock_nxt = 1'b1;
          end
        end else begin
          w_run_nxt = '0;
          if (r_lock) begin
            w_lock_nxt = 1'b0;
            w_lost_nxt = 1'b1;
          end
        end
        // This cycle's edge opens the next window so windows abut exactly.
        if (EN) begin
          w_state_nxt = GATE;
          w_win_nxt   = '0;
          w_ecnt_nxt  = {{(CNT_WIDTH-1){1'b0}}, w_edge};
          w_ovf_nxt   = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign COUNT       = r_count;
  assign COUNT_VALID = r_valid;
  assign IN_RANGE    = r_in;
  assign OVERFLOW    = r_ovfo;
  assign LOCK        = r_lock;
  assign LOST        = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_freq_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pll_freq_monitor
//  Description : Self-checking bench for pll_freq_monitor. A window-level
//                reference model predicts every output each cycle; directed
//                phases pin literal counts, lock timing and boundaries, then
//                a randomized phase varies period, enable, limits and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_freq_monitor;

  localparam int W    = 1000;
  localparam int CW   = 16;
  localparam int LC   = 4;
  localparam int SS   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          EN = 1'b0;
  logic          MEAS_CLK = 1'b0;
  logic [CW-1:0] MIN_COUNT = '0;
  logic [CW-1:0] MAX_COUNT = '0;
  logic [CW-1:0] COUNT;
  logic          COUNT_VALID, IN_RANGE, OVERFLOW, LOCK, LOST;

  // Second instance with an 8-bit counter to exercise saturation.
  logic          EN2 = 1'b0;
  logic          MEAS2 = 1'b0;
  logic [7:0]    MIN2 = 8'd0;
  logic [7:0]    MAX2 = 8'd255;
  logic [7:0]    COUNT2;
  logic          VALID2, IN2, OVF2, LOCK2, LOST2;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  bit done2  = 1'b0;
  int lost_seen  = 0;
  int valid_seen = 0;

  int meas_period = 4;   // 0 means hold meas_level
  bit meas_level  = 1'b0;
  int meas_ph     = 0;

  pll_freq_monitor #(
    .WINDOW_CYCLES (W), .CNT_WIDTH (CW), .LOCK_COUNT (LC), .SYNC_STAGES (SS)
  ) dut (
    .CLK (CLK), .RESET_N (RESET_N), .EN (EN), .MEAS_CLK (MEAS_CLK),
    .MIN_COUNT (MIN_COUNT), .MAX_COUNT (MAX_COUNT),
    .COUNT (COUNT), .COUNT_VALID (COUNT_VALID), .IN_RANGE (IN_RANGE),
    .OVERFLOW (OVERFLOW), .LOCK (LOCK), .LOST (LOST)
  );

  pll_freq_monitor #(
    .WINDOW_CYCLES (W), .CNT_WIDTH (8), .LOCK_COUNT (LC), .SYNC_STAGES (SS)
  ) dut_ovf (
    .CLK (CLK), .RESET_N (RESET_N), .EN (EN2), .MEAS_CLK (MEAS2),
    .MIN_COUNT (MIN2), .MAX_COUNT (MAX2),
    .COUNT (COUNT2), .COUNT_VALID (VALID2), .IN_RANGE (IN2),
    .OVERFLOW (OVF2), .LOCK (LOCK2), .LOST (LOST2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Measured clocks change a few ns after the falling reference edge,
  // well clear of the sampling edge.
  initial begin : meas_gen
    forever begin
      @(negedge CLK);
      #($urandom_range(0, 3));
      MEAS2 = ~MEAS2;
      if (meas_period >= 2) begin
        meas_ph  = (meas_ph + 1) % meas_period;
        MEAS_CLK = (meas_ph < meas_period / 2);
      end else begin
        MEAS_CLK = meas_level;
      end
    end
  end

  // ---------------- reference model ----------------
  // The rising edge counted at reference edge k is the 0->1 step between the
  // MEAS_CLK samples taken at edges k-SS-1 and k-SS. A window is W consecutive
  // such samples; its result is visible after the following edge.
  bit [SS+1:0]   m_smp;
  bit            m_busy;
  int            m_pos, m_acc, m_good;
  logic [CW-1:0] e_count;
  logic          e_valid, e_in, e_ovf, e_lock, e_lost;

  initial begin : model
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (RESET_N !== 1'b1) begin
        m_smp = '0; m_busy = 0; m_pos = 0; m_acc = 0; m_good = 0;
        e_count = '0; e_valid = 0; e_in = 0; e_ovf = 0; e_lock = 0; e_lost = 0;
      end else begin
        bit rise;
        bit ovf;
        int cnt;
        m_smp = {m_smp[SS:0], MEAS_CLK};
        rise  = m_smp[SS] & ~m_smp[SS+1];
        e_valid = 0;
        e_lost  = 0;
        if (!m_busy) begin
          if (EN) begin m_busy = 1; m_pos = 1; m_acc = int'(rise); end
        end else if (m_pos < W) begin
          if (!EN) begin
            m_busy = 0; e_lock = 0; m_good = 0;
          end else begin
            m_acc += int'(rise); m_pos++;
          end
        end else begin
          ovf     = (m_acc > CMAX);
          cnt     = ovf ? CMAX : m_acc;
          e_count = cnt[CW-1:0];
          e_ovf   = ovf;
          e_in    = !ovf && (int'(MIN_COUNT) <= cnt) && (cnt <= int'(MAX_COUNT));
          e_valid = 1;
          if (e_in) begin
            if (m_good < LC) m_good++;
            if (m_good >= LC) e_lock = 1;
          end else begin
            m_good = 0;
            if (e_lock) begin e_lock = 0; e_lost = 1; end
          end
          if (EN) begin m_pos = 1; m_acc = int'(rise); end
          else m_busy = 0;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge CLK);
      if (chk_on) begin
        chk("model_count",    32'(COUNT),       32'(e_count));
        chk("model_valid",    32'(COUNT_VALID), 32'(e_valid));
        chk("model_in_range", 32'(IN_RANGE),    32'(e_in));
        chk("model_overflow", 32'(OVERFLOW),    32'(e_ovf));
        chk("model_lock",     32'(LOCK),        32'(e_lock));
        chk("model_lost",     32'(LOST),        32'(e_lost));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (LOST) lost_seen++;
    end while (!COUNT_VALID && n < limit);
    chk("valid_within_budget", 32'(COUNT_VALID), 32'd1);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (LOST) lost_seen++;
      if (COUNT_VALID) valid_seen++;
    end
  endtask

  // ---------------- saturation instance ----------------
  initial begin : ovf_test
    int n2;
    repeat (8) @(negedge CLK);
    EN2 = 1'b1;
    repeat (2) begin
      n2 = 0;
      do begin @(negedge CLK); n2++; end while (!VALID2 && n2 < 1100);
      chk("ovf_valid",    32'(VALID2), 32'd1);
      chk("ovf_count",    32'(COUNT2), 32'd255);
      chk("ovf_flag",     32'(OVF2),   32'd1);
      chk("ovf_in_range", 32'(IN2),    32'd0);
      chk("ovf_lock",     32'(LOCK2),  32'd0);
    end
    done2 = 1'b1;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    int n;
    MIN_COUNT = 16'd248;
    MAX_COUNT = 16'd252;
    repeat (2) @(negedge CLK);
    chk_on = 1'b1;
    chk("reset_count",    32'(COUNT),       32'd0);
    chk("reset_valid",    32'(COUNT_VALID), 32'd0);
    chk("reset_in_range", 32'(IN_RANGE),    32'd0);
    chk("reset_lock",     32'(LOCK),        32'd0);
    #2 RESET_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Period 4: 250 edges per window, LOCK with the 4th result.
    EN = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_valid(1100, n);
      chk("p4_spacing",  32'(n), (i == 1) ? 32'd1001 : 32'd1000);
      chk("p4_count",    32'(COUNT),    32'd250);
      chk("p4_in_range", 32'(IN_RANGE), 32'd1);
      chk("p4_lock",     32'(LOCK),     (i >= 4) ? 32'd1 : 32'd0);
    end

    // Switch to period 5 while locked.
    lost_seen = 0;
    run_cycles(300);
    meas_period = 5;
    wait_valid(1100, n);
    chk("p5_straddle_in_range", 32'(IN_RANGE), 32'd0);
    chk("p5_straddle_lost",     32'(LOST),     32'd1);
    chk("p5_straddle_lock",     32'(LOCK),     32'd0);
    wait_valid(1100, n);
    chk("p5_count",     32'(COUNT),    32'd200);
    chk("p5_in_range",  32'(IN_RANGE), 32'd0);
    chk("p5_lost_once", 32'(lost_seen), 32'd1);

    // Restore period 4 mid-window and re-qualify.
    run_cycles(500);
    meas_period = 4;
    wait_valid(1100, n);
    chk("p4_restore_straddle", 32'(IN_RANGE), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      wait_valid(1100, n);
      chk("relock_count", 32'(COUNT), 32'd250);
      chk("relock_lock",  32'(LOCK),  (i == 4) ? 32'd1 : 32'd0);
    end

    // Drop EN half way through a window while locked.
    run_cycles(500);
    EN = 1'b0;
    valid_seen = 0;
    lost_seen  = 0;
    run_cycles(1100);
    chk("en_drop_no_valid", 32'(valid_seen), 32'd0);
    chk("en_drop_no_lost",  32'(lost_seen),  32'd0);
    chk("en_drop_lock",     32'(LOCK),       32'd0);
    chk("en_drop_count",    32'(COUNT),      32'd250);
    EN = 1'b1;
    wait_valid(1100, n);
    chk("en_raise_latency", 32'(n),     32'd1001);
    chk("en_raise_count",   32'(COUNT), 32'd250);

    // Static MEAS_CLK.
    meas_period = 0;
    meas_level  = 1'b0;
    lost_seen   = 0;
    wait_valid(1100, n);
    for (int i = 0; i < 2; i++) begin
      wait_valid(1100, n);
      chk("static_count",    32'(COUNT),    32'd0);
      chk("static_in_range", 32'(IN_RANGE), 32'd0);
      chk("static_lock",     32'(LOCK),     32'd0);
    end
    chk("static_no_lost", 32'(lost_seen), 32'd0);

    // Lock again, then reset mid-window.
    meas_period = 4;
    for (int i = 0; i < 6; i++) wait_valid(1100, n);
    chk("pre_reset_lock", 32'(LOCK), 32'd1);
    run_cycles(400);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_count",    32'(COUNT),       32'd0);
    chk("async_rst_valid",    32'(COUNT_VALID), 32'd0);
    chk("async_rst_in_range", 32'(IN_RANGE),    32'd0);
    chk("async_rst_overflow", 32'(OVERFLOW),    32'd0);
    chk("async_rst_lock",     32'(LOCK),        32'd0);
    chk("async_rst_lost",     32'(LOST),        32'd0);
    EN = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    EN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_valid(1100, n);
      if (i == 1) chk("post_rst_latency", 32'(n), 32'd1001);
      chk("post_rst_count", 32'(COUNT), 32'd250);
      chk("post_rst_lock",  32'(LOCK),  (i == 4) ? 32'd1 : 32'd0);
    end

    // Inclusive bound, then an inverted range.
    MIN_COUNT = 16'd250;
    MAX_COUNT = 16'd250;
    wait_valid(1100, n);
    chk("bound_equal_in_range", 32'(IN_RANGE), 32'd1);
    MIN_COUNT = 16'd251;
    MAX_COUNT = 16'd249;
    wait_valid(1100, n);
    chk("inverted_in_range", 32'(IN_RANGE), 32'd0);
    chk("inverted_lost",     32'(LOST),     32'd1);

    // Randomized phase, checked cycle by cycle against the model.
    for (int k = 0; k < 30; k++) begin
      run_cycles($urandom_range(50, 700));
      case ($urandom_range(0, 5))
        0, 1: begin
          case ($urandom_range(0, 7))
            0: meas_period = 0;
            1: meas_period = 2;
            2: meas_period = 3;
            3: meas_period = 5;
            4: meas_period = 6;
            5: meas_period = 8;
            default: meas_period = 4;
          endcase
          meas_level = ($urandom_range(0, 1) == 1);
        end
        2: EN = ($urandom_range(0, 3) != 0);
        3: begin
          MIN_COUNT = 16'($urandom_range(0, 300));
          MAX_COUNT = 16'($urandom_range(0, 300));
        end
        4: begin
          MIN_COUNT = 16'(1000 / ((meas_period >= 2) ? meas_period : 4) - 1);
          MAX_COUNT = MIN_COUNT + 16'd2;
        end
        default: begin
          #2 RESET_N = 1'b0;
          #10 RESET_N = 1'b1;
        end
      endcase
    end
    run_cycles(1200);

    for (int i = 0; i < 5000 && !done2; i++) @(negedge CLK);
    chk("ovf_instance_done", 32'(done2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
